// File: rtl/aes128_cipher_round_pkg.sv
// Shared types and helpers for the AES-128 cipher round datapath.
// FSM encodings, byte-order reversal, GF(2^8) xtime and ShiftRows.
package aes128_cipher_round_pkg;

  // Final round index for full AES-128.
  localparam int N_ROUNDS_AES = 10;

  // FSM state encodings.
  typedef logic [2:0] aes_fsm_t;
  localparam aes_fsm_t ST_IDLE  = 3'd0;
  localparam aes_fsm_t ST_LOAD  = 3'd1;
  localparam aes_fsm_t ST_KWAIT = 3'd2;
  localparam aes_fsm_t ST_ARK   = 3'd3;
  localparam aes_fsm_t ST_SUB   = 3'd4;
  localparam aes_fsm_t ST_SHIFT = 3'd5;
  localparam aes_fsm_t ST_MIX   = 3'd6;
  localparam aes_fsm_t ST_DONE  = 3'd7;

  // Swap between big-endian I/O order and internal order (byte 0 at [7:0]).
  function automatic logic [127:0] aes_reverse_bytes(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      r[8*b +: 8] = x[8*(15-b) +: 8];
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8), reduction polynomial 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // ShiftRows on internal order: byte (col c, row r) lives at index 4*c+r;
  // row r takes its byte from column (c+r) mod 4.
  function automatic logic [127:0] aes_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_cipher_round_mix_column.sv
// Combinational MixColumns for one 32-bit column (row r at [8r+:8]).
module aes128_cipher_round_mix_column
  import aes128_cipher_round_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign w_a0 = i_col[7:0];
  assign w_a1 = i_col[15:8];
  assign w_a2 = i_col[23:16];
  assign w_a3 = i_col[31:24];

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // Circulant matrix {02,03,01,01}; 3*a is xtime(a)^a.
  assign o_col[7:0]   = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
  assign o_col[31:24] = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes128_cipher_round.sv
// AES-128 encryption datapath fed by an external key expander and a
// shared, combinational S-box used one byte per cycle.
// Optional debug ports: define AES128_CIPHER_DEBUG_EN.
//
// Handshakes: start_i is a pulse honoured only in IDLE. key_start_o and
// key_req_o are single-cycle pulses; the expander answers with a registered
// key_valid_i, so valid is ignored in the cycle right after either pulse and
// accepted from then on, with round_key_i sampled in that same cycle.
module aes128_cipher_round
  import aes128_cipher_round_pkg::*;
#(
  parameter int N_ROUNDS = N_ROUNDS_AES
)(
  input  logic         clk_i,
  input  logic         rst_i,
`ifdef AES128_CIPHER_DEBUG_EN
  output logic [3:0]   dbg_round_o,
  output logic [127:0] dbg_state_o,
  output logic [2:0]   dbg_fsm_o,
`endif
  input  logic         start_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o,
  output logic         done_o,
  output logic         busy_o,
  output logic         key_start_o,
  output logic         key_req_o,
  input  logic [127:0] round_key_i,
  input  logic         key_valid_i,
  output logic [7:0]   sbox_sub_o,
  input  logic [7:0]   sbox_sub_i
);

  localparam logic [3:0] LP_LAST = 4'(N_ROUNDS);

  aes_fsm_t     r_fsm;
  logic [127:0] r_state;
  logic [127:0] r_data;
  logic [3:0]   r_round;
  logic [3:0]   r_byte_cnt;
  logic         r_key_pulse;

  logic [127:0] w_ark;
  logic [127:0] w_mix;
  logic [7:0]   w_sub_byte;

  assign w_ark      = r_state ^ round_key_i;
  assign w_sub_byte = r_state[{r_byte_cnt, 3'b000} +: 8];

  // Four MixColumns units, one per column of the state.
  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes128_cipher_round_mix_column u_mix (
      .i_col (r_state[32*c +: 32]),
      .o_col (w_mix[32*c +: 32])
    );
  end

  assign data_o      = r_data;
  assign done_o      = (r_fsm == ST_DONE);
  assign busy_o      = (r_fsm != ST_IDLE);
  assign key_start_o = (r_fsm == ST_LOAD);
  assign key_req_o   = (r_fsm == ST_SUB) && (r_byte_cnt == 4'd0);
  assign sbox_sub_o  = (r_fsm == ST_SUB) ? w_sub_byte : 8'h00;

`ifdef AES128_CIPHER_DEBUG_EN
  assign dbg_round_o = r_round;
  assign dbg_state_o = r_state;
  assign dbg_fsm_o   = r_fsm;
`endif

  // Round sequencer and state register; the key-fetch for the next round
  // is requested at the start of SubBytes so it overlaps the S-box pass.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm       <= ST_IDLE;
      r_state     <= '0;
      r_data      <= '0;
      r_round     <= '0;
      r_byte_cnt  <= '0;
      r_key_pulse <= 1'b0;
    end else begin
      r_key_pulse <= key_start_o | key_req_o;
      case (r_fsm)
        ST_IDLE: begin
          if (start_i) r_fsm <= ST_LOAD;
        end
        ST_LOAD: begin
          r_state <= aes_reverse_bytes(data_i);
          r_round <= '0;
          r_fsm   <= ST_KWAIT;
        end
        ST_KWAIT: begin
          if (key_valid_i && !r_key_pulse) r_fsm <= ST_ARK;
        end
        ST_ARK: begin
          r_state <= w_ark;
          if (r_round == LP_LAST) begin
            r_data <= aes_reverse_bytes(w_ark);
            r_fsm  <= ST_DONE;
          end else begin
            r_round <= r_round + 4'd1;
            r_fsm   <= ST_SUB;
          end
        end
        ST_SUB: begin
          r_state[{r_byte_cnt, 3'b000} +: 8] <= sbox_sub_i;
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'd15) r_fsm <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_state <= aes_shift_rows(r_state);
          r_fsm   <= (r_round < LP_LAST) ? ST_MIX : ST_KWAIT;
        end
        ST_MIX: begin
          r_state <= w_mix;
          r_fsm   <= ST_KWAIT;
        end
        ST_DONE: begin
          r_fsm <= ST_IDLE;
        end
        default: begin
          r_fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
